x2050_stctl: RTL

Main-storage cycle controller for the 2050 datapath. It accepts word-read, word-write and byte-write requests from two requesters, the CPU microcode and the channel, and arbitrates a single storage port between them. Byte writes are sequenced as read-merge-write so that storage always sees full 32-bit words. The word read back feeds the M/T register path. While a CPU request is outstanding, the block holds ROS advance.

---
 rtl/x2050_stctl.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/x2050_stctl.sv
// x2050_stctl: main-storage cycle controller for the 2050 datapath.
// Arbitrates one storage port between the CPU microcode and the channel.
// Word reads, word writes and byte writes are supported. A byte write runs
// as read-merge-write, so storage only ever sees full 32-bit words.
// Optional feature: define X2050_STCTL_PARITY_EN to add per-byte odd parity
// on the storage port (o_st_wpar / i_st_rpar) and the sticky o_perr flag.
// Parity bit k covers data bits [8k+7:8k], so bit 3 belongs to byte 0.

module x2050_stctl #(
    parameter int RD_LAT = 2,
    parameter int AW     = 24
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_cpu_req,
    input  logic [1:0]    i_cpu_op,
    input  logic [AW-1:0] i_cpu_addr,
    input  logic [31:0]   i_cpu_wdata,
    output logic          o_cpu_ack,
    input  logic          i_ch_req,
    input  logic [1:0]    i_ch_op,
    input  logic [AW-1:0] i_ch_addr,
    input  logic [31:0]   i_ch_wdata,
    output logic          o_ch_ack,
    output logic [31:0]   o_rdata,
    output logic [AW-3:0] o_st_addr,
    output logic          o_st_rd,
    output logic          o_st_wr,
    output logic [31:0]   o_st_wdata,
    input  logic [31:0]   i_st_rdata,
`ifdef X2050_STCTL_PARITY_EN
    output logic [3:0]    o_st_wpar,
    input  logic [3:0]    i_st_rpar,
    output logic          o_perr,
`endif
    output logic          o_ros_hold,
    output logic          o_busy
);

    typedef enum logic [2:0] {IDLE, RD, RWAIT, MERGE, WR, DONE} state_t;

    localparam logic [2:0] WAIT_LAST = 3'(RD_LAT - 1);

    state_t        state;
    logic          owner_cpu;
    logic          byte_op;
    logic [1:0]    byte_off;
    logic [7:0]    byte_data;
    logic [2:0]    wait_cnt;
    logic [1:0]    fair_cnt;

    logic          grant_ch;
    logic          grant_cpu;
    logic [1:0]    sel_op;
    logic [AW-1:0] sel_addr;
    logic [31:0]   sel_wdata;
    logic [31:0]   merged;

`ifdef X2050_STCTL_PARITY_EN
    logic [3:0]    par_keep;

    function automatic logic [3:0] odd_par(input logic [31:0] w);
        logic [3:0] p;
        for (int k = 0; k < 4; k++) begin
            p[k] = ~^w[8*k +: 8];
        end
        return p;
    endfunction

    // Ignore the parity of the byte a byte write is about to overwrite
    always_comb begin
        par_keep = 4'hF;
        if (byte_op) begin
            par_keep = ~(4'b1000 >> byte_off);
        end
    end
`endif

    // Channel wins unless the CPU has already waited through two channel grants
    always_comb begin
        grant_ch  = i_ch_req && !(i_cpu_req && fair_cnt == 2'd2);
        grant_cpu = i_cpu_req && !grant_ch;
        sel_op    = i_cpu_op;
        sel_addr  = i_cpu_addr;
        sel_wdata = i_cpu_wdata;
        if (grant_ch) begin
            sel_op    = i_ch_op;
            sel_addr  = i_ch_addr;
            sel_wdata = i_ch_wdata;
        end
    end

    // Drop the latched write byte into its lane; byte 0 is the most significant
    always_comb begin
        merged = o_rdata;
        case (byte_off)
            2'd0: merged[31:24] = byte_data;
            2'd1: merged[23:16] = byte_data;
            2'd2: merged[15:8]  = byte_data;
            default: merged[7:0] = byte_data;
        endcase
    end

    assign o_ros_hold = i_cpu_req & ~o_cpu_ack;

    // Storage cycle sequencer; every strobe and ack is registered on entry to its state
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state      <= IDLE;
            owner_cpu  <= 1'b0;
            byte_op    <= 1'b0;
            byte_off   <= 2'd0;
            byte_data  <= 8'h00;
            wait_cnt   <= 3'd0;
            fair_cnt   <= 2'd0;
            o_cpu_ack  <= 1'b0;
            o_ch_ack   <= 1'b0;
            o_rdata    <= 32'h0;
            o_st_addr  <= '0;
            o_st_rd    <= 1'b0;
            o_st_wr    <= 1'b0;
            o_st_wdata <= 32'h0;
            o_busy     <= 1'b0;
`ifdef X2050_STCTL_PARITY_EN
            o_st_wpar  <= 4'h0;
            o_perr     <= 1'b0;
`endif
        end else begin
            o_st_rd   <= 1'b0;
            o_st_wr   <= 1'b0;
            o_cpu_ack <= 1'b0;
            o_ch_ack  <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_ch || grant_cpu) begin
                        owner_cpu <= grant_cpu;
                        byte_op   <= (sel_op == 2'd2);
                        byte_off  <= sel_addr[1:0];
                        byte_data <= sel_wdata[7:0];
                        o_st_addr <= sel_addr[AW-1:2];
                        o_busy    <= 1'b1;
                        if (grant_cpu) begin
                            fair_cnt <= 2'd0;
                        end else if (i_cpu_req && fair_cnt != 2'd2) begin
                            fair_cnt <= fair_cnt + 2'd1;
                        end
                        if (sel_op == 2'd1) begin
                            state      <= WR;
                            o_st_wr    <= 1'b1;
                            o_st_wdata <= sel_wdata;
`ifdef X2050_STCTL_PARITY_EN
                            o_st_wpar  <= odd_par(sel_wdata);
`endif
                        end else begin
                            state   <= RD;
                            o_st_rd <= 1'b1;
                        end
                    end
                end
                RD: begin
                    state    <= RWAIT;
                    wait_cnt <= 3'd0;
                end
                RWAIT: begin
                    if (wait_cnt == WAIT_LAST) begin
                        o_rdata <= i_st_rdata;
`ifdef X2050_STCTL_PARITY_EN
                        if (|((odd_par(i_st_rdata) ^ i_st_rpar) & par_keep)) begin
                            o_perr <= 1'b1;
                        end
`endif
                        if (byte_op) begin
                            state <= MERGE;
                        end else begin
                            state     <= DONE;
                            o_cpu_ack <= owner_cpu;
                            o_ch_ack  <= !owner_cpu;
                        end
                    end else begin
                        wait_cnt <= wait_cnt + 3'd1;
                    end
                end
                MERGE: begin
                    state      <= WR;
                    o_st_wr    <= 1'b1;
                    o_st_wdata <= merged;
`ifdef X2050_STCTL_PARITY_EN
                    o_st_wpar  <= odd_par(merged);
`endif
                end
                WR: begin
                    state     <= DONE;
                    o_cpu_ack <= owner_cpu;
                    o_ch_ack  <= !owner_cpu;
                end
                DONE: begin
                    state  <= IDLE;
                    o_busy <= 1'b0;
                end
                default: begin
                    state  <= IDLE;
                    o_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule
